// File: rtl/lwc_post_processor.sv
// lwc_post_processor: turns the crypto core's bdo / msg_auth stream plus the
// forwarded command words into the public 32-bit data-out stream (segment
// headers, masked data words, tag segment on encrypt, final status word).
module lwc_post_processor #(
  parameter int unsigned W         = 32,
  parameter int unsigned TAG_BYTES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cmd,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] bdo,
  input  logic         bdo_valid,
  output logic         bdo_ready,
  input  logic [3:0]   bdo_type,
  input  logic         end_of_block,
  input  logic         msg_auth,
  input  logic         msg_auth_valid,
  output logic         msg_auth_ready,
  output logic [W-1:0] do_data,
  output logic         do_valid,
  input  logic         do_ready,
  output logic         do_last
);

  localparam int unsigned LEN_W     = 16;
  localparam int unsigned TAG_WORDS = TAG_BYTES / 4;
  localparam int unsigned TCNT_W    = $clog2(TAG_WORDS + 1);

  localparam logic [3:0] OP_ENC   = 4'b0010;
  localparam logic [3:0] OP_DEC   = 4'b0011;
  localparam logic [3:0] TYPE_TAG = 4'b1000;

  localparam logic [W-1:0] TAG_HDR_WORD = W'({4'b1000, 2'b00, 1'b1, 1'b1, 8'h00, 16'(TAG_BYTES)});
  localparam logic [W-1:0] STAT_OK      = W'(32'hE000_0000);
  localparam logic [W-1:0] STAT_FAIL    = W'(32'hF000_0000);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_HDR_OUT,
    S_DATA,
    S_NEXT,
    S_TAG_HDR,
    S_TAG,
    S_AUTH,
    S_STAT
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [W-1:0]        hdr_q, hdr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                last_q, last_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                pass_q, pass_d;

  logic                cmd_ready_c;
  logic                bdo_ready_c;
  logic                msg_auth_ready_c;
  logic                do_valid_c;
  logic                do_last_c;
  logic [W-1:0]        do_data_c;

  logic [LEN_W-1:0]    len_take_c;
  logic [LEN_W-1:0]    len_rem_c;
  logic [W-1:0]        len_mask_c;
  logic                bdo_is_msg_c;

  // Informational only; the segment length already tells us where blocks end.
  logic unused_eob;
  assign unused_eob = end_of_block;

  // Remaining-length bookkeeping and byte mask for the current data word.
  always_comb begin
    len_take_c   = (len_q >= LEN_W'(4)) ? LEN_W'(4) : len_q;
    len_rem_c    = len_q - len_take_c;
    bdo_is_msg_c = (bdo_type != TYPE_TAG);
    if (len_q >= LEN_W'(4)) begin
      len_mask_c = '1;
    end else begin
      len_mask_c = ~({W{1'b1}} >> {len_q[1:0], 3'b000});
    end
  end

  // Next-state and handshake/output decode.
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    hdr_d            = hdr_q;
    len_d            = len_q;
    last_d           = last_q;
    tcnt_d           = tcnt_q;
    pass_d           = pass_q;
    cmd_ready_c      = 1'b0;
    bdo_ready_c      = 1'b0;
    msg_auth_ready_c = 1'b0;
    do_valid_c       = 1'b0;
    do_last_c        = 1'b0;
    do_data_c        = '0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid) begin
          op_d = cmd[31:28];
          if ((cmd[31:28] == OP_ENC) || (cmd[31:28] == OP_DEC)) begin
            state_d = S_HDR;
          end else begin
            pass_d  = 1'b0;
            state_d = S_STAT;
          end
        end
      end

      S_HDR: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid) begin
          hdr_d   = cmd;
          len_d   = cmd[LEN_W-1:0];
          last_d  = cmd[24];
          state_d = S_HDR_OUT;
        end
      end

      S_HDR_OUT: begin
        do_valid_c = 1'b1;
        do_data_c  = hdr_q;
        if (do_ready) begin
          state_d = (len_q != '0) ? S_DATA : S_NEXT;
        end
      end

      // Tag-typed words are held back here; they belong to the tag segment.
      S_DATA: begin
        do_valid_c  = bdo_valid & bdo_is_msg_c;
        bdo_ready_c = do_ready & bdo_is_msg_c;
        do_data_c   = bdo & len_mask_c;
        if (bdo_valid && bdo_is_msg_c && do_ready) begin
          len_d = len_rem_c;
          if (len_rem_c == '0) begin
            state_d = S_NEXT;
          end
        end
      end

      S_NEXT: begin
        if (!last_q) begin
          state_d = S_HDR;
        end else if (op_q == OP_ENC) begin
          state_d = S_TAG_HDR;
        end else begin
          state_d = S_AUTH;
        end
      end

      S_TAG_HDR: begin
        do_valid_c = 1'b1;
        do_data_c  = TAG_HDR_WORD;
        if (do_ready) begin
          tcnt_d  = '0;
          state_d = S_TAG;
        end
      end

      S_TAG: begin
        do_valid_c  = bdo_valid;
        bdo_ready_c = do_ready;
        do_data_c   = bdo;
        if (bdo_valid && do_ready) begin
          tcnt_d = tcnt_q + TCNT_W'(1);
          if (tcnt_q == TCNT_W'(TAG_WORDS - 1)) begin
            pass_d  = 1'b1;
            state_d = S_STAT;
          end
        end
      end

      S_AUTH: begin
        msg_auth_ready_c = 1'b1;
        if (msg_auth_valid) begin
          pass_d  = msg_auth;
          state_d = S_STAT;
        end
      end

      S_STAT: begin
        do_valid_c = 1'b1;
        do_last_c  = 1'b1;
        do_data_c  = pass_q ? STAT_OK : STAT_FAIL;
        if (do_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // While reset is asserted every handshake and the pending do word are suppressed.
  assign cmd_ready      = cmd_ready_c & ~rst;
  assign bdo_ready      = bdo_ready_c & ~rst;
  assign msg_auth_ready = msg_auth_ready_c & ~rst;
  assign do_valid       = do_valid_c & ~rst;
  assign do_last        = do_last_c & ~rst;
  assign do_data        = rst ? '0 : do_data_c;

  // State and context registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      hdr_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      tcnt_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
      pass_q  <= pass_d;
    end
  end

endmodule

// File: tb/tb_lwc_post_processor.sv
// Directed bench for lwc_post_processor: encrypt/decrypt flows, masking,
// empty message, back-pressure, bad opcode and mid-operation reset.
module tb_lwc_post_processor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] bdo;
  logic        bdo_valid;
  logic        bdo_ready;
  logic [3:0]  bdo_type;
  logic        end_of_block;
  logic        msg_auth;
  logic        msg_auth_valid;
  logic        msg_auth_ready;
  logic [31:0] do_data;
  logic        do_valid;
  logic        do_ready;
  logic        do_last;

  int n_cmp = 0;
  int n_bad = 0;

  logic [35:0] bdo_src[$];   // {bdo_type, bdo}
  logic [32:0] got[$];       // {do_last, do_data}
  bit          stall_en = 1'b0;

  always #5 clk = ~clk;

  lwc_post_processor dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (cmd),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .bdo            (bdo),
    .bdo_valid      (bdo_valid),
    .bdo_ready      (bdo_ready),
    .bdo_type       (bdo_type),
    .end_of_block   (end_of_block),
    .msg_auth       (msg_auth),
    .msg_auth_valid (msg_auth_valid),
    .msg_auth_ready (msg_auth_ready),
    .do_data        (do_data),
    .do_valid       (do_valid),
    .do_ready       (do_ready),
    .do_last        (do_last)
  );

  // Core-side source: presents bdo_src words in order and the sink's do_ready.
  initial begin
    bit take;
    bdo       = '0;
    bdo_valid = 1'b0;
    bdo_type  = '0;
    do_ready  = 1'b1;
    forever begin
      @(negedge clk);
      take = bdo_valid && bdo_ready;
      @(posedge clk);
      #1;
      if (take && bdo_src.size() > 0) void'(bdo_src.pop_front());
      bdo_valid = (bdo_src.size() > 0);
      if (bdo_valid) {bdo_type, bdo} = bdo_src[0];
      do_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Records every do transfer (sampled mid-cycle, completes at the next edge).
  always @(negedge clk) begin
    if (!rst && do_valid && do_ready) got.push_back({do_last, do_data});
  end

  task automatic send_cmd(input logic [31:0] w);
    bit acc;
    acc = 1'b0;
    @(posedge clk);
    #1;
    cmd       = w;
    cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cmd_accept: word %h not accepted, required within 300 cycles", w);
    end
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      if (got.size() >= n) break;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (do_valid !== 1'b0) begin n_bad++; $display("FAIL rst_do_valid: got %b want 0", do_valid); end
    n_cmp++; if (do_last !== 1'b0) begin n_bad++; $display("FAIL rst_do_last: got %b want 0", do_last); end
    n_cmp++; if (do_data !== 32'h0) begin n_bad++; $display("FAIL rst_do_data: got %h want 00000000", do_data); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    n_cmp++; if (bdo_ready !== 1'b0) begin n_bad++; $display("FAIL rst_bdo_ready: got %b want 0", bdo_ready); end
    n_cmp++; if (msg_auth_ready !== 1'b0) begin n_bad++; $display("FAIL rst_auth_ready: got %b want 0", msg_auth_ready); end
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_enc();
    logic [32:0] exp[$];
    @(negedge clk);
    got.delete();
    bdo_src = '{{4'h1, 32'h0123_4567}, {4'h1, 32'h89AB_CDEF},
                {4'h8, 32'hA0A1_A2A3}, {4'h8, 32'hB0B1_B2B3},
                {4'h8, 32'hC0C1_C2C3}, {4'h8, 32'hD0D1_D2D3}};
    exp = '{{1'b0, 32'h5300_0008}, {1'b0, 32'h0123_4567}, {1'b0, 32'h89AB_CDEF},
            {1'b0, 32'h8300_0010}, {1'b0, 32'hA0A1_A2A3}, {1'b0, 32'hB0B1_B2B3},
            {1'b0, 32'hC0C1_C2C3}, {1'b0, 32'hD0D1_D2D3}, {1'b1, 32'hE000_0000}};
    send_cmd(32'h2000_0000);
    send_cmd(32'h5300_0008);
    wait_got(exp.size());
    n_cmp++;
    if (got.size() != exp.size()) begin
      n_bad++; $display("FAIL enc_count: got %0d words want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++; $display("FAIL enc_word%0d: got last/data %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_dec(input logic auth);
    logic [32:0] exp[$];
    @(negedge clk);
    got.delete();
    bdo_src = '{{4'h1, 32'hAABB_CCDD}, {4'h1, 32'h1122_3344}};
    msg_auth       = auth;
    msg_auth_valid = 1'b1;
    exp = '{{1'b0, 32'h4300_0005}, {1'b0, 32'hAABB_CCDD}, {1'b0, 32'h1100_0000},
            {1'b1, auth ? 32'hE000_0000 : 32'hF000_0000}};
    send_cmd(32'h3000_0000);
    send_cmd(32'h4300_0005);
    @(negedge clk);
    n_cmp++;
    if (msg_auth_ready !== 1'b0) begin
      n_bad++; $display("FAIL dec_auth_holdoff: got %b want 0", msg_auth_ready);
    end
    wait_got(exp.size());
    @(negedge clk);
    msg_auth_valid = 1'b0;
    n_cmp++;
    if (got.size() != exp.size()) begin
      n_bad++; $display("FAIL dec%0d_count: got %0d words want %0d", auth, got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++; $display("FAIL dec%0d_word%0d: got last/data %h want %h", auth, i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_empty_enc();
    logic [32:0] exp[$];
    @(negedge clk);
    got.delete();
    bdo_src = '{{4'h8, 32'h1010_1010}, {4'h8, 32'h2020_2020},
                {4'h8, 32'h3030_3030}, {4'h8, 32'h4040_4040}};
    exp = '{{1'b0, 32'h5300_0000}, {1'b0, 32'h8300_0010}, {1'b0, 32'h1010_1010},
            {1'b0, 32'h2020_2020}, {1'b0, 32'h3030_3030}, {1'b0, 32'h4040_4040},
            {1'b1, 32'hE000_0000}};
    send_cmd(32'h2000_0000);
    send_cmd(32'h5300_0000);
    @(negedge clk);
    n_cmp++;
    if (bdo_ready !== 1'b0) begin
      n_bad++; $display("FAIL empty_bdo_ready: got %b want 0 before tag", bdo_ready);
    end
    wait_got(exp.size());
    n_cmp++;
    if (got.size() != exp.size()) begin
      n_bad++; $display("FAIL empty_count: got %0d words want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++; $display("FAIL empty_word%0d: got last/data %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [32:0] exp[$];
    logic        pv, pr, pl;
    logic [31:0] pd;
    @(negedge clk);
    got.delete();
    stall_en = 1'b1;
    bdo_src = '{{4'h1, 32'h1111_1111}, {4'h1, 32'h2222_2222},
                {4'h1, 32'h3333_3333}, {4'h1, 32'h4444_4444},
                {4'h8, 32'h5555_5555}, {4'h8, 32'h6666_6666},
                {4'h8, 32'h7777_7777}, {4'h8, 32'h8888_8888}};
    exp = '{{1'b0, 32'h5300_000D}, {1'b0, 32'h1111_1111}, {1'b0, 32'h2222_2222},
            {1'b0, 32'h3333_3333}, {1'b0, 32'h4400_0000}, {1'b0, 32'h8300_0010},
            {1'b0, 32'h5555_5555}, {1'b0, 32'h6666_6666}, {1'b0, 32'h7777_7777},
            {1'b0, 32'h8888_8888}, {1'b1, 32'hE000_0000}};
    send_cmd(32'h2000_0000);
    send_cmd(32'h5300_000D);
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    for (int c = 0; c < 3000 && got.size() < exp.size(); c++) begin
      @(negedge clk);
      if (pv && !pr) begin
        n_cmp++;
        if (do_valid !== 1'b1 || do_data !== pd || do_last !== pl) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", do_valid, do_data, do_last, pd, pl);
        end
      end
      pv = do_valid; pr = do_ready; pd = do_data; pl = do_last;
    end
    @(posedge clk);
    stall_en = 1'b0;
    n_cmp++;
    if (got.size() != exp.size()) begin
      n_bad++; $display("FAIL stall_count: got %0d words want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++; $display("FAIL stall_word%0d: got last/data %h want %h", i, got[i], exp[i]);
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_bad_opcode();
    @(negedge clk);
    got.delete();
    send_cmd(32'h7000_0000);
    wait_got(1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (got.size() != 1) begin
      n_bad++; $display("FAIL badop_count: got %0d words want 1", got.size());
    end
    if (got.size() > 0) begin
      n_cmp++;
      if (got[0] !== {1'b1, 32'hF000_0000}) begin
        n_bad++; $display("FAIL badop_status: got last/data %h want 1f0000000", got[0]);
      end
    end
    n_cmp++;
    if (cmd_ready !== 1'b1 || do_valid !== 1'b0) begin
      n_bad++; $display("FAIL badop_idle: got cmd_ready=%b do_valid=%b want 1/0", cmd_ready, do_valid);
    end
  endtask

  task automatic test_reset_mid_tag();
    logic [32:0] exp[$];
    @(negedge clk);
    got.delete();
    bdo_src = '{{4'h1, 32'h5A5A_5A5A}, {4'h8, 32'hC1C1_C1C1}, {4'h8, 32'hC2C2_C2C2},
                {4'h8, 32'hC3C3_C3C3}, {4'h8, 32'hC4C4_C4C4}};
    send_cmd(32'h2000_0000);
    send_cmd(32'h5300_0004);
    wait_got(5);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    rst       = 1'b0;
    bdo_src.delete();
    bdo_valid = 1'b0;
    got.delete();
    @(negedge clk);
    n_cmp++;
    if (do_valid !== 1'b0 || do_last !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_do: got valid=%b last=%b want 0/0", do_valid, do_last);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_idle: got cmd_ready=%b want 1", cmd_ready);
    end
    got.delete();
    bdo_src = '{{4'h1, 32'h0BAD_F00D}, {4'h8, 32'hD1D1_D1D1}, {4'h8, 32'hD2D2_D2D2},
                {4'h8, 32'hD3D3_D3D3}, {4'h8, 32'hD4D4_D4D4}};
    exp = '{{1'b0, 32'h5300_0004}, {1'b0, 32'h0BAD_F00D}, {1'b0, 32'h8300_0010},
            {1'b0, 32'hD1D1_D1D1}, {1'b0, 32'hD2D2_D2D2}, {1'b0, 32'hD3D3_D3D3},
            {1'b0, 32'hD4D4_D4D4}, {1'b1, 32'hE000_0000}};
    send_cmd(32'h2000_0000);
    send_cmd(32'h5300_0004);
    wait_got(exp.size());
    n_cmp++;
    if (got.size() != exp.size()) begin
      n_bad++; $display("FAIL rstmid_count: got %0d words want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_bad++; $display("FAIL rstmid_word%0d: got last/data %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    cmd            = '0;
    cmd_valid      = 1'b0;
    end_of_block   = 1'b0;
    msg_auth       = 1'b0;
    msg_auth_valid = 1'b0;
    test_reset();
    test_enc();
    test_dec(1'b0);
    test_dec(1'b1);
    test_empty_enc();
    test_stall();
    test_bad_opcode();
    test_reset_mid_tag();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lwc_post_processor.md
Name: lwc_post_processor

Overview:
Downstream neighbour of the SpoC-64 crypto core. It consumes the core's bdo/msg_auth stream and the command words forwarded by the pre-processor, and emits the external 32-bit public data-out stream. That stream carries segment headers, masked ciphertext/plaintext words, an internally generated tag segment (encrypt only) and a final status word. Only ENC and DEC opcodes are supported; any other opcode yields a failure status.

Parameters:
W, 32, data/bdo word width in bits
TAG_BYTES, 16, tag length; tag segment carries TAG_BYTES/4 words

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
cmd  in  32  command FIFO word: instruction, then output-segment header
cmd_valid  in  1  cmd word available
cmd_ready  out  1  cmd word consumed this cycle when cmd_valid & cmd_ready
bdo  in  32  core output word (byte 3 = bits 31:24 = first byte)
bdo_valid  in  1  core word valid
bdo_ready  out  1  core word accepted
bdo_type  in  4  core word type; 1000 = tag, else message data
end_of_block  in  1  informational; ignored
msg_auth  in  1  1 = tag match (decrypt)
msg_auth_valid  in  1  msg_auth valid
msg_auth_ready  out  1  verdict consumed
do_data  out  32  public output word
do_valid  out  1  do_data valid
do_ready  in  1  sink accepts
do_last  out  1  high with the status word only

Behaviour:
- Header format: [31:28] type, [25] eot, [24] last, [15:0] length in bytes; other bits forwarded unchanged. Instruction format: [31:28] opcode, 0010 = ENC, 0011 = DEC.
- Reset (synchronous): state=IDLE; cmd_ready, bdo_ready, msg_auth_ready, do_valid, do_last = 0; do_data = 0; counters cleared. Reset mid-operation discards everything, including a pending do word.
- The do stream obeys valid/ready. Once do_valid is high, do_data and do_last stay stable until do_ready. A transfer occurs on do_valid & do_ready.
- IDLE: cmd_ready=1. On accepted instruction, latch op and go to HDR.
  - Unsupported opcode: status=FAIL, go to STAT.
- HDR: cmd_ready=1. On accepted header, register it onto do_data with do_valid=1, latch len=cmd[15:0] and last=cmd[24], go to HDR_OUT.
- HDR_OUT: on do transfer, go to DATA if len!=0. Otherwise go to NEXT.
- DATA (combinational pass-through): do_valid=bdo_valid, bdo_ready=do_ready.
  - do_data = bdo with bytes at or beyond the remaining length zeroed. rem>=4 gives mask FFFFFFFF; 3 gives FFFFFF00; 2 gives FFFF0000; 1 gives FF000000.
  - On transfer: len -= min(4,len). At 0, go to NEXT.
  - bdo_type=1000 words are never passed in DATA.
- NEXT: if !last, go to HDR (further data segment). If last & ENC, go to TAG_HDR. If last & DEC, go to AUTH.
- TAG_HDR: drive do_data = {4'b1000, 2'b00, 1'b1, 1'b1, 8'h00, TAG_BYTES[15:0]} (0x8300_0010 at default). On transfer, tcnt=0, go to TAG.
- TAG: pass-through of bdo as in DATA, no masking. Each transfer increments tcnt; after TAG_BYTES/4 words, status=SUCCESS, go to STAT.
- AUTH: msg_auth_ready=1. On msg_auth_valid, status=msg_auth ? SUCCESS : FAIL, go to STAT.
  - Verdicts arriving in any other state are held off (msg_auth_ready=0).
- STAT: do_valid=1, do_data = 0xE000_0000 (SUCCESS) or 0xF000_0000 (FAIL), do_last=1. On transfer, go to IDLE.
- Back-pressure: do_ready=0 stalls every state; no word is dropped or duplicated. cmd_ready and bdo_ready are 0 outside the states listed above.
- Zero-length final segment (empty message): header emitted, DATA skipped. ENC still emits the tag; DEC still waits for the verdict.
- Throughput: one word per cycle in DATA/TAG while bdo_valid & do_ready hold. Header words add one register cycle of latency.

Test Plan:
- ENC, header 0x5300_0008 (CT, eot, last, len 8), two bdo words, four tag words, do_ready=1 -> do sequence: 0x5300_0008, 2 data words, 0x8300_0010, 4 tag words, 0xE000_0000 with do_last=1.
- DEC, len 5, bdo words 0xAABBCCDD, 0x11223344, msg_auth=0 -> data out 0xAABBCCDD, 0x11000000; status 0xF000_0000, do_last=1. Repeat with msg_auth=1 -> 0xE000_0000.
- Empty ENC message (len 0) -> header, tag header, 4 tag words, status; bdo_ready stays 0 until TAG.
- Random do_ready deassertion (50%) during ENC len 13 -> do_data stable while stalled; 4 data words with last masked to FF000000; output identical to the no-stall run.
- Instruction opcode 0111 -> single word 0xF000_0000, do_last=1, return to IDLE.
- rst pulsed during TAG (tcnt=2) -> next cycle do_valid=0, cmd_ready=1 (IDLE); a fresh ENC completes correctly.
